// File: rtl/level_to_pulse_if.sv
// Level-to-pulse channel bundle.
//   level_i : level inputs, one bit per channel (driven by the master side)
//   pulse_o : registered pulse outputs, one bit per channel (driven by the converter)
interface level_to_pulse_if #(
    parameter int unsigned WIDTH = 1
);
    logic [WIDTH-1:0] level_i;
    logic [WIDTH-1:0] pulse_o;

    // Producer of the levels / consumer of the pulses.
    modport master (output level_i, input pulse_o);
    // The converter itself.
    modport slave  (input level_i, output pulse_o);
endinterface

// File: rtl/level_to_pulse.sv
// Level-to-pulse converter: each qualifying transition on a level input
// produces one registered pulse of PULSE_LEN clk cycles. A qualifying edge
// during an active pulse restarts the count (the pulse is extended, never
// split or queued). Channels are independent and identical.
//   clk            : single clock, rising edge
//   rst            : asynchronous, active-high reset
//   bus.level_i    : WIDTH level inputs
//   bus.pulse_o    : WIDTH registered pulse outputs
module level_to_pulse #(
    parameter int unsigned WIDTH       = 1,
    parameter int unsigned SYNC_STAGES = 0,   // 0..4, 0 = already synchronous
    parameter int unsigned EDGE_MODE   = 0,   // 0 rise, 1 fall, 2 both
    parameter int unsigned PULSE_LEN   = 1    // 1..255
) (
    input  logic               clk,
    input  logic               rst,
    level_to_pulse_if.slave    bus
);
    localparam int unsigned CNT_W = $clog2(PULSE_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_LEN - 1);

    logic [WIDTH-1:0] lvl_s;

    // Optional synchroniser chain; stage 0 samples the raw input.
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign lvl_s = bus.level_i;
        end else begin : g_sync
            logic [WIDTH-1:0] sync_q [SYNC_STAGES];
            logic [WIDTH-1:0] sync_d [SYNC_STAGES];

            always_comb begin
                sync_d[0] = bus.level_i;
                for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                    sync_d[i] = sync_q[i-1];
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= '0;
                    end
                end else begin
                    for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_d[i];
                    end
                end
            end

            assign lvl_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    logic [WIDTH-1:0] lvl_q,   lvl_d;
    logic [WIDTH-1:0] pulse_q, pulse_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] rise, fall, sel;

    // Edge detect and per-channel pulse counter.
    always_comb begin
        lvl_d   = lvl_s;
        rise    = lvl_s & ~lvl_q;
        fall    = ~lvl_s & lvl_q;
        sel     = rise;
        pulse_d = '0;
        case (EDGE_MODE)
            0:       sel = rise;
            1:       sel = fall;
            default: sel = rise | fall;
        endcase
        for (int unsigned ch = 0; ch < WIDTH; ch++) begin
            cnt_d[ch] = cnt_q[ch];
            if (sel[ch]) begin
                // New or retriggering edge: this cycle is the first of PULSE_LEN.
                cnt_d[ch]   = CNT_LOAD;
                pulse_d[ch] = 1'b1;
            end else if (cnt_q[ch] != '0) begin
                cnt_d[ch]   = cnt_q[ch] - CNT_W'(1);
                pulse_d[ch] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl_q   <= '0;
            pulse_q <= '0;
            for (int unsigned ch = 0; ch < WIDTH; ch++) begin
                cnt_q[ch] <= '0;
            end
        end else begin
            lvl_q   <= lvl_d;
            pulse_q <= pulse_d;
            for (int unsigned ch = 0; ch < WIDTH; ch++) begin
                cnt_q[ch] <= cnt_d[ch];
            end
        end
    end

    assign bus.pulse_o = pulse_q;

endmodule

// File: tb/tb_level_to_pulse.sv
// Directed bench for level_to_pulse: six instances with different parameter
// sets share clk/rst. Inputs change on the falling edge; each vector entry is
// the level applied before a rising edge and the pulse expected after it.
module tb_level_to_pulse;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    level_to_pulse_if #(.WIDTH(1)) if0 ();
    level_to_pulse_if #(.WIDTH(1)) if1 ();
    level_to_pulse_if #(.WIDTH(1)) if2 ();
    level_to_pulse_if #(.WIDTH(1)) if3 ();
    level_to_pulse_if #(.WIDTH(1)) if4 ();
    level_to_pulse_if #(.WIDTH(1)) if5 ();

    level_to_pulse u_def  (.clk(clk), .rst(rst), .bus(if0.slave));
    level_to_pulse #(.EDGE_MODE(1)) u_fall (.clk(clk), .rst(rst), .bus(if1.slave));
    level_to_pulse #(.EDGE_MODE(2)) u_both (.clk(clk), .rst(rst), .bus(if2.slave));
    level_to_pulse #(.PULSE_LEN(4)) u_len4 (.clk(clk), .rst(rst), .bus(if3.slave));
    level_to_pulse #(.SYNC_STAGES(2)) u_sync (.clk(clk), .rst(rst), .bus(if4.slave));
    level_to_pulse #(.PULSE_LEN(8)) u_len8 (.clk(clk), .rst(rst), .bus(if5.slave));

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_lvl(input int id, input logic v);
        case (id)
            0: if0.level_i = v;
            1: if1.level_i = v;
            2: if2.level_i = v;
            3: if3.level_i = v;
            4: if4.level_i = v;
            default: if5.level_i = v;
        endcase
    endtask

    function automatic logic get_pulse(input int id);
        case (id)
            0: return if0.pulse_o[0];
            1: return if1.pulse_o[0];
            2: return if2.pulse_o[0];
            3: return if3.pulse_o[0];
            4: return if4.pulse_o[0];
            default: return if5.pulse_o[0];
        endcase
    endfunction

    // Apply one level per cycle, check the pulse after the following rising edge.
    task automatic run_vec(input int id, input string tag, input string lv, input string ex);
        for (int k = 0; k < lv.len(); k++) begin
            set_lvl(id, lv[k] == "1");
            @(negedge clk);
            check_eq($sformatf("%s[%0d]", tag, k), 32'(get_pulse(id)), 32'(ex[k] == "1"));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        for (int i = 0; i < 6; i++) set_lvl(i, 1'b0);
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 6; i++) check_eq($sformatf("reset_state%0d", i), 32'(get_pulse(i)), 32'd0);
        rst = 1'b0;

        // Rising edge, single-cycle pulses; held level gives no further pulse.
        run_vec(0, "rise_default", "0110111110", "0100100000");
        // Falling mode: pulses only on 1->0.
        run_vec(1, "fall_mode",    "0111000110", "0000100001");
        // Both edges, spaced then toggling on consecutive edges.
        run_vec(2, "both_mode",    "011111000001011", "010000100001110");
        // PULSE_LEN=4 with retriggers while active.
        run_vec(3, "len4_retrig",  "0110011111110101111111", "0111111110000111111000");
        // Two synchroniser stages: pulse appears two edges later.
        run_vec(4, "sync2",        "01111110011111", "00010000000100");

        // PULSE_LEN=8: reset in the third pulse cycle, release with level high.
        run_vec(5, "len8_pre",     "0111", "0111");
        rst = 1'b1;
        #1;
        check_eq("len8_async_rst", 32'(get_pulse(5)), 32'd0);
        @(negedge clk);
        check_eq("len8_rst_held", 32'(get_pulse(5)), 32'd0);
        rst = 1'b0;
        run_vec(5, "len8_post",    "1111111111", "1111111100");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
